fifo_read_cnt: RTL and testbench
================================

Name: fifo_read_cnt

Overview:
Drains a capture FIFO that was filled by the ADC write path and presents the samples as a ready/valid stream with a frame-end marker. One `start` pulse reads exactly `frame_len` words from a standard-mode FIFO (dout valid one cycle after rd_en). The block owns the FIFO read port, stalls on `empty` and on downstream back-pressure, and pulses `done` when the last word has been accepted.

Parameters:
FIFO_WIDTH, 12, width of FIFO dout and stream data
CNT_WIDTH, 16, width of frame length and internal counters

Ports:
clk  input  1  single clock for all logic
rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk
start  input  1  request one frame; sampled only in IDLE
frame_len  input  CNT_WIDTH  words per frame; latched when start is accepted
empty  input  1  FIFO empty flag
dout  input  FIFO_WIDTH  FIFO read data, valid the cycle after rd_en && !empty
rd_en  output  1  FIFO read strobe
m_data  output  FIFO_WIDTH  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready
m_last  output  1  high with the final word of the frame
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. rd_en=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0. All counters and the output buffer are cleared.
- Reset mid-frame: in-flight FIFO data is discarded, and the stream is truncated without m_last. FIFO contents are not flushed.
- States:
  - IDLE: start=1 with frame_len!=0 latches len and moves to READ. start=1 with frame_len==0 pulses done the next cycle and stays in IDLE; no rd_en is issued.
  - READ: issues reads. When issued==len (after the final rd_en), moves to DRAIN.
  - DRAIN: no reads are issued. When the beat with m_last is accepted (m_valid && m_ready), moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start while busy is ignored.
- rd_en is combinational: (state==READ) && !empty && (issued<len) && (occ+inflight<3).
  - occ is the number of words held in the 3-entry output FIFO.
  - inflight is a 1-bit flag set on the edge after rd_en.
  - rd_en never asserts while empty=1.
  - rd_en has no combinational path from m_ready.
- Capture: on the edge after rd_en, inflight=1. On the following edge, dout is written into the output buffer.
  - A simultaneous push and pop leaves occ unchanged.
  - occ never exceeds 3; overflow is impossible by construction and is checked by assertion.
- Stream output:
  - m_valid = (occ!=0). m_data is the buffer head, registered from storage.
  - Data is held stable while m_valid && !m_ready.
  - m_last = m_valid && (accepted==len-1).
- Latency: start accepted at edge E0 → rd_en high in the cycle after E0 (if !empty) → m_valid high after E0+2.
- Throughput: with empty=0 and m_ready=1, one beat per cycle sustained.
- Counters:
  - issued and accepted are CNT_WIDTH bits and compare against the latched len.
  - Maximum frame is 2^CNT_WIDTH-1 words.
  - Counters do not wrap within a frame.
- empty during READ: reads stall and resume automatically. There is no timeout.
- done and the return to IDLE occur exactly once per accepted start.

Optional Feature:
FIFO_READ_OFFSET_BIN_EN
- Defined: the MSB of dout is inverted as each word is written into the output buffer. This converts offset-binary ADC codes to two's complement; e.g. 12'h800 becomes 12'h000 and 12'h000 becomes 12'h800.
- Not defined: data passes unchanged.
- Timing and handshakes are identical in both builds.

Test Plan:
- FIFO preloaded with 8 words 0x001..0x008, frame_len=8, m_ready=1, start pulse → m_valid first high 2 cycles after start. 8 consecutive beats 0x001..0x008. m_last on 0x008 only. done one cycle after the last accept. Exactly 8 rd_en cycles.
- Same frame with m_ready toggling 1,0,0,1 repeating → identical data order. m_data stable while stalled. rd_en never asserts with occ+inflight=3. No word lost or duplicated.
- FIFO holds 3 words, frame_len=6; 3 more words written 20 cycles later → rd_en stops while empty=1. Stream resumes and completes with 6 beats and m_last on the 6th. busy=1 throughout.
- frame_len=0 start → no rd_en, no m_valid, done pulses once. Also: start asserted during READ → ignored; frame_len is not re-latched.
- rst_n=0 for one cycle after 4 of 10 beats → all outputs return to reset values the next cycle. A new start with frame_len=2 streams the next FIFO words correctly.
- FIFO_READ_OFFSET_BIN_EN defined, dout words 0x800, 0x7FF, 0x000 → m_data 0x000, 0xFFF, 0x800.

Source files
------------

// File: rtl/fifo_read_cnt.sv
// Frame reader: drains exactly frame_len words from a standard-mode FIFO into a
// ready/valid stream with m_last. Define FIFO_READ_OFFSET_BIN_EN to invert the data MSB.
module fifo_read_cnt #(
  parameter int FIFO_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  frame_len,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] dout,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    len_q, len_d;
  logic [CNT_WIDTH-1:0]    issued_q, issued_d;
  logic [CNT_WIDTH-1:0]    accepted_q, accepted_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              occ_q, occ_d;
  logic [1:0]              wr_ptr_q, wr_ptr_d;
  logic [1:0]              rd_ptr_q, rd_ptr_d;
  logic                    zero_done_q, zero_done_d;
  logic [FIFO_WIDTH-1:0]   buf_q [0:2];

  logic                    start_ok;
  logic                    push;
  logic                    pop;
  logic [2:0]              occ_sum;
  logic [FIFO_WIDTH-1:0]   wr_data;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign start_ok = (state_q == S_IDLE) && start;
  assign push     = inflight_q;
  assign pop      = m_valid && m_ready;
  // Reserve buffer room for the word already requested but not yet captured.
  assign occ_sum  = {1'b0, occ_q} + {2'b00, inflight_q};

`ifdef FIFO_READ_OFFSET_BIN_EN
  assign wr_data = {~dout[FIFO_WIDTH-1], dout[FIFO_WIDTH-2:0]};
`else
  assign wr_data = dout;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_en && ((issued_q + CNT_ONE) == len_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; rd_en deliberately ignores m_ready to keep it off the stream path.
  always_comb begin
    rd_en   = (state_q == S_READ) && !empty && (issued_q < len_q) && (occ_sum < 3'd3);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE) || zero_done_q;
    m_valid = (occ_q != 2'd0);
    m_last  = m_valid && (accepted_q == (len_q - CNT_ONE));
    m_data  = buf_q[rd_ptr_q];
  end

  always_comb begin
    len_d       = len_q;
    issued_d    = issued_q;
    accepted_d  = accepted_q;
    inflight_d  = rd_en;
    occ_d       = occ_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    zero_done_d = start_ok && (frame_len == '0);

    if (start_ok) begin
      issued_d   = '0;
      accepted_d = '0;
      if (frame_len != '0) begin
        len_d = frame_len;
      end
    end else begin
      if (rd_en) begin
        issued_d = issued_q + CNT_ONE;
      end
      if (pop) begin
        accepted_d = accepted_q + CNT_ONE;
      end
    end

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      zero_done_q <= 1'b0;
    end else begin
      len_q       <= len_d;
      issued_q    <= issued_d;
      accepted_q  <= accepted_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      zero_done_q <= zero_done_d;
    end
  end

  // Three-entry output buffer; cleared on reset so m_data reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else if (push) begin
      buf_q[wr_ptr_q] <= wr_data;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      occ_overflow: assert (!(push && !pop && (occ_q == 2'd3)));
    end
  end

endmodule

// File: tb/tb_fifo_read_cnt.sv
// Directed bench for fifo_read_cnt: behavioural FIFO source, stream monitor and
// one task per scenario with inline comparisons.
module tb_fifo_read_cnt;

  localparam int W  = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] frame_len;
  logic          empty;
  logic [W-1:0]  dout = '0;
  logic          rd_en;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_read_cnt #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .empty     (empty),
    .dout      (dout),
    .rd_en     (rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  // Standard-mode FIFO source model
  logic [W-1:0] fmem [0:127];
  int wr_i = 0;
  int rd_i = 0;
  assign empty = (wr_i == rd_i);

  always @(posedge clk) begin
    if (rd_en && !empty) begin
      dout <= fmem[rd_i];
      rd_i <= rd_i + 1;
    end
  end

  // Stream monitor, sampled on the falling edge
  logic         mon_clr = 1'b0;
  int           cyc, rd_cnt, acc_cnt, done_cnt, valid_cnt, busy_cnt, last_cnt;
  int           occ_viol, empty_viol, stall_viol;
  int           start_cyc, first_valid, done_cyc, last_cyc;
  logic [W-1:0] beats [0:31];
  logic         lasts [0:31];
  bit           prev_stall;
  logic [W-1:0] prev_data;

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc = 0; rd_cnt = 0; acc_cnt = 0; done_cnt = 0; valid_cnt = 0;
      busy_cnt = 0; last_cnt = 0; occ_viol = 0; empty_viol = 0; stall_viol = 0;
      start_cyc = -1; first_valid = -1; done_cyc = -1; last_cyc = -1;
      prev_stall = 1'b0; prev_data = '0;
    end else if (rst_n) begin
      cyc++;
      if (start && start_cyc < 0) start_cyc = cyc;
      if (rd_en) begin
        if (rd_cnt - acc_cnt >= 3) occ_viol++;
        if (empty) empty_viol++;
        rd_cnt++;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data)) stall_viol++;
      if (m_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (m_valid && m_ready) begin
        if (acc_cnt < 32) begin
          beats[acc_cnt] = m_data;
          lasts[acc_cnt] = m_last;
        end
        if (m_last) begin
          last_cnt++;
          last_cyc = cyc;
        end
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    fmem[wr_i] = v;
    wr_i = wr_i + 1;
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [CW-1:0] len);
    tick();
    start = 1'b1;
    frame_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; frame_len = '0; m_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({rd_en, m_valid, m_last, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want %b", {rd_en, m_valid, m_last, busy, done}, 5'b0);
    end
    checks++;
    if (m_data !== 12'h000) begin
      errors++;
      $display("FAIL reset_data got %h want %h", m_data, 12'h000);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    for (int i = 1; i <= 8; i++) push(W'(i));
    m_ready = 1'b1;
    clr();
    pulse_start(16'd8);
    wait_done(60, ok);
    repeat (3) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got %0d want %0d", 0, 1); end
    checks++;
    if (acc_cnt != 8) begin errors++; $display("FAIL basic_beats got %0d want %0d", acc_cnt, 8); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (beats[i] !== W'(i + 1)) begin
        errors++;
        $display("FAIL basic_data[%0d] got %h want %h", i, beats[i], W'(i + 1));
      end
    end
    checks++;
    if (last_cnt != 1 || lasts[7] !== 1'b1) begin
      errors++;
      $display("FAIL basic_last got count %0d flag7 %b want count 1 flag7 1", last_cnt, lasts[7]);
    end
    checks++;
    if (first_valid != start_cyc + 3) begin
      errors++;
      $display("FAIL basic_latency got %0d want %0d", first_valid - start_cyc, 3);
    end
    checks++;
    if (done_cyc != last_cyc + 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done got delay %0d count %0d want delay 1 count 1", done_cyc - last_cyc, done_cnt);
    end
    checks++;
    if (rd_cnt != 8) begin errors++; $display("FAIL basic_rd_en got %0d want %0d", rd_cnt, 8); end
  endtask

  task automatic test_backpressure();
    bit ok = 1'b0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 9; i <= 16; i++) push(W'(i));
    m_ready = 1'b1;
    clr();
    tick();
    start = 1'b1;
    frame_len = 16'd8;
    for (int k = 0; k < 100; k++) begin
      tick();
      start = 1'b0;
      m_ready = pat[k % 4];
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (!ok || acc_cnt != 8) begin
      errors++;
      $display("FAIL bp_beats got %0d want %0d", acc_cnt, 8);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (beats[i] !== W'(i + 9)) begin
        errors++;
        $display("FAIL bp_data[%0d] got %h want %h", i, beats[i], W'(i + 9));
      end
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d want %0d", stall_viol, 0); end
    checks++;
    if (occ_viol != 0) begin errors++; $display("FAIL bp_occupancy got %0d want %0d", occ_viol, 0); end
    checks++;
    if (last_cnt != 1 || lasts[7] !== 1'b1 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_last got last %0d done %0d want last 1 done 1", last_cnt, done_cnt);
    end
  endtask

  task automatic test_empty_stall();
    bit ok = 1'b0;
    int busy_drop = 0;
    m_ready = 1'b1;
    clr();
    for (int i = 0; i < 3; i++) push(W'(12'h021 + i));
    pulse_start(16'd6);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!busy) busy_drop++;
    end
    checks++;
    if (rd_cnt != 3 || acc_cnt != 3 || done_cnt != 0) begin
      errors++;
      $display("FAIL empty_stall got rd %0d acc %0d done %0d want rd 3 acc 3 done 0", rd_cnt, acc_cnt, done_cnt);
    end
    for (int i = 3; i < 6; i++) push(W'(12'h021 + i));
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      if (!busy) busy_drop++;
    end
    repeat (2) tick();
    checks++;
    if (!ok || acc_cnt != 6) begin errors++; $display("FAIL empty_beats got %0d want %0d", acc_cnt, 6); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (beats[i] !== W'(12'h021 + i)) begin
        errors++;
        $display("FAIL empty_data[%0d] got %h want %h", i, beats[i], W'(12'h021 + i));
      end
    end
    checks++;
    if (last_cnt != 1 || lasts[5] !== 1'b1) begin
      errors++;
      $display("FAIL empty_last got count %0d flag5 %b want count 1 flag5 1", last_cnt, lasts[5]);
    end
    checks++;
    if (busy_drop != 0) begin errors++; $display("FAIL empty_busy got %0d want %0d", busy_drop, 0); end
    checks++;
    if (empty_viol != 0 || rd_cnt != 6) begin
      errors++;
      $display("FAIL empty_rd_en got rd %0d on_empty %0d want rd 6 on_empty 0", rd_cnt, empty_viol);
    end
  endtask

  task automatic test_zero_len();
    clr();
    pulse_start(16'd0);
    repeat (5) tick();
    checks++;
    if (rd_cnt != 0 || valid_cnt != 0 || busy_cnt != 0) begin
      errors++;
      $display("FAIL zero_activity got rd %0d valid %0d busy %0d want 0 0 0", rd_cnt, valid_cnt, busy_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
      errors++;
      $display("FAIL zero_done got count %0d delay %0d want count 1 delay 1", done_cnt, done_cyc - start_cyc);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    m_ready = 1'b1;
    clr();
    for (int i = 0; i < 4; i++) push(W'(12'h031 + i));
    pulse_start(16'd4);
    tick();
    start = 1'b1;
    frame_len = 16'd2;
    tick();
    start = 1'b0;
    wait_done(60, ok);
    repeat (6) tick();
    checks++;
    if (!ok || acc_cnt != 4 || rd_cnt != 4) begin
      errors++;
      $display("FAIL ignore_beats got acc %0d rd %0d want acc 4 rd 4", acc_cnt, rd_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (beats[i] !== W'(12'h031 + i)) begin
        errors++;
        $display("FAIL ignore_data[%0d] got %h want %h", i, beats[i], W'(12'h031 + i));
      end
    end
    checks++;
    if (last_cnt != 1 || lasts[3] !== 1'b1 || done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_last got last %0d done %0d want last 1 done 1", last_cnt, done_cnt);
    end
  endtask

`ifdef FIFO_READ_OFFSET_BIN_EN
  task automatic test_offset_bin();
    bit ok;
    logic [W-1:0] exp_v [3] = '{12'h000, 12'hFFF, 12'h800};
    m_ready = 1'b1;
    clr();
    push(12'h800);
    push(12'h7FF);
    push(12'h000);
    pulse_start(16'd3);
    wait_done(40, ok);
    repeat (2) tick();
    checks++;
    if (!ok || acc_cnt != 3) begin errors++; $display("FAIL offset_beats got %0d want %0d", acc_cnt, 3); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (beats[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL offset_data[%0d] got %h want %h", i, beats[i], exp_v[i]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok = 1'b0;
    logic [W-1:0] exp0, exp1;
    m_ready = 1'b1;
    clr();
    for (int i = 0; i < 10; i++) push(W'(12'h041 + i));
    pulse_start(16'd10);
    for (int k = 0; k < 40; k++) begin
      if (acc_cnt >= 4) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_progress got %0d want %0d", acc_cnt, 4); end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({rd_en, m_valid, m_last, busy, done} !== 5'b0 || m_data !== 12'h000) begin
      errors++;
      $display("FAIL midrst_outputs got ctrl %b data %h want ctrl 00000 data 000",
               {rd_en, m_valid, m_last, busy, done}, m_data);
    end
    rst_n = 1'b1;
    clr();
    exp0 = fmem[rd_i];
    exp1 = fmem[rd_i + 1];
    pulse_start(16'd2);
    wait_done(40, ok);
    repeat (3) tick();
    checks++;
    if (!ok || acc_cnt != 2 || rd_cnt != 2) begin
      errors++;
      $display("FAIL midrst_beats got acc %0d rd %0d want acc 2 rd 2", acc_cnt, rd_cnt);
    end
    checks++;
    if (beats[0] !== exp0 || beats[1] !== exp1) begin
      errors++;
      $display("FAIL midrst_data got %h %h want %h %h", beats[0], beats[1], exp0, exp1);
    end
    checks++;
    if (last_cnt != 1 || lasts[1] !== 1'b1 || done_cnt != 1) begin
      errors++;
      $display("FAIL midrst_last got last %0d done %0d want last 1 done 1", last_cnt, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero_len();
    test_start_ignored();
`ifdef FIFO_READ_OFFSET_BIN_EN
    test_offset_bin();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
